fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 7 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared lock-state type and round-robin index helper for fifo_wr_arbiter.
package fifo_arb_pkg;
  typedef enum logic {ARB, LOCKED} lock_state_e;
  function automatic int rr_next(input int cur, input int step, input int n);
    return (cur + step) % n;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: one-hot round-robin pick, searching from the index after ptr and wrapping.
module rr_picker import fifo_arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
  // Walk from lowest priority (ptr itself) to highest (ptr+1) so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = ptr;
    c = ptr;
    for (int i = N; i >= 1; i--) begin
      c = IW'(rr_next(int'(ptr), i, N));
      if (req[c]) begin
        gnt = N'(1) << c;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter feeding a sync_fifo with occupancy tracking.
// Optional burst lock enabled by defining FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int IW = $clog2(NUM_REQ),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  input  logic                          fifo_rd_en_i,
  input  logic                          fifo_empty_i,
  input  logic                          fifo_full_i,
  output logic [LW-1:0]                 level_o,
  output logic                          err_o
);
  logic [IW-1:0] ptr, idx;
  logic [NUM_REQ-1:0] eligible, pick;
  logic room, any, rd_acc;
  assign rd_acc = fifo_rd_en_i && !fifo_empty_i;
  assign room = rst_ni && (level_o < LW'(DEPTH));
`ifdef FIFO_ARB_LOCK_EN
  lock_state_e state, state_n;
  // While locked, ptr still names the lock owner because it was the last grant.
  assign eligible = (state == LOCKED) ? (req_i & (NUM_REQ'(1) << ptr)) : req_i;
  always_comb begin
    state_n = state;
    if (any) state_n = lock_i[idx] ? LOCKED : ARB;
  end
  always_ff @(posedge clk_i) state <= !rst_ni ? ARB : state_n;
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign eligible = req_i;
`endif
  rr_picker #(.N(NUM_REQ)) u_pick (.req(eligible), .ptr(ptr), .gnt(pick), .idx(idx));
  assign gnt_o = room ? pick : '0;
  assign any = |gnt_o;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo_wr_en_o <= 1'b0;
      fifo_wr_data_o <= '0;
      level_o <= '0;
      err_o <= 1'b0;
      ptr <= IW'(NUM_REQ - 1);
    end else begin
      fifo_wr_en_o <= any;
      if (any) begin
        fifo_wr_data_o <= data_i[idx*DATA_WIDTH +: DATA_WIDTH];
        ptr <= idx;
      end
      level_o <= level_o + LW'(any) - LW'(rd_acc && level_o != '0);
      if ((fifo_wr_en_o && fifo_full_i) || (rd_acc && level_o == '0)) err_o <= 1'b1;
    end
  end
endmodule
